tb_conv_encoder: RTL and testbench
==================================

Name: tb_conv_encoder

Overview:
- Rate-1/2, constraint-length-7 tail-biting convolutional encoder, generators G1=171 (octal) and G2=133 (octal).
- Sits directly downstream of the randomizer. It consumes the randomized serial bitstream one bit per accepted cycle and buffers one FEC block.
- It then emits one (X,Y) coded pair per accepted cycle toward the interleaver.
- Tail-biting: the encoder state is preloaded with the last 6 bits of the block, so no tail bits are appended.

Parameters:
- BLOCK_BITS, 96, uncoded bits per FEC block; legal range 7..1024.
- CNT_W, 10, counter width; must satisfy 2^CNT_W > BLOCK_BITS.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-high reset.
- input_data, input, 1, randomized serial data bit.
- in_valid, input, 1, input_data is valid this cycle.
- in_ready, output, 1, encoder can accept a bit this cycle.
- out_data, output, 2, coded pair: [1]=X (G1), [0]=Y (G2).
- out_valid, output, 1, out_data is valid.
- out_ready, input, 1, downstream accepts out_data this cycle.
- out_last, output, 1, current out_data is the final pair of the block.

Behaviour:
- One clock; reset is synchronous and active-high. No asynchronous reset and no initial-block values.
- Reset values (all outputs): in_ready=0 on the reset cycle and 1 on the first cycle after reset; out_valid=0; out_last=0; out_data=2'b00. Reset also clears the bit counter, the block buffer and the state, and enters COLLECT.
- Reset mid-block, in either state, discards the partial input or partial output. No pair of the aborted block appears after reset.
- FSM state COLLECT:
  - in_ready=1, out_valid=0.
  - Input handshake: a bit is accepted when in_valid and in_ready are both 1.
  - Accepted bits are stored in order; the first accepted bit is d[0].
  - On acceptance of d[BLOCK_BITS-1]: go to ENCODE on the next edge, clear the counter, and load the state as s1=d[N-1], s2=d[N-2], ..., s6=d[N-6], where N=BLOCK_BITS.
- FSM state ENCODE:
  - in_ready=0; no input is accepted, regardless of in_valid.
  - Pair k (k=0..N-1) uses b=d[k] and the current s1..s6:
    - X = b^s1^s2^s3^s6
    - Y = b^s2^s3^s5^s6
  - Output handshake: a pair transfers when out_valid and out_ready are both 1.
  - On transfer, the state shifts: s6<=s5, ..., s2<=s1, s1<=b, and k increments.
  - out_valid=1 for the whole ENCODE state. While out_ready=0, out_data and out_last hold stable.
  - out_last=1 only for k=N-1.
  - When pair N-1 transfers, return to COLLECT; in_ready=1 on the next cycle.
  - After pair N-1 the state must equal its initial value (tail-biting property). The bench checks this through an internal probe.
- Latency and throughput:
  - out_data and out_valid are registered.
  - Pair 0 is valid in the first cycle after the cycle in which d[N-1] was accepted.
  - Throughput is one bit per cycle in and one pair per cycle out. This gives N collect cycles plus N encode cycles per block with no stalls; no input/output overlap is required.
- Boundary conditions:
  - in_valid gaps in COLLECT pause collection.
  - out_ready gaps in ENCODE pause encoding.
  - in_valid=1 during ENCODE is ignored, and no bit is lost from the next block. in_ready=0 is upstream's signal to hold.
  - The counter wraps only through the explicit clear at block end; it never exceeds N-1.

Test Plan:
1. Reset, then an all-zero block (N=96) with in_valid held high → in_ready low for 96 cycles; 96 pairs of 2'b00; out_last only on pair 95.
2. All-ones block → every pair 2'b11.
3. d[0]=1, rest 0 → pairs 0..6 (X,Y) = 11,10,11,11,00,01,11; pairs 7..95 = 00.
4. d[95]=1, rest 0 (tail-biting) → pairs 0..5 = 10,11,11,00,01,11; pairs 6..94 = 00; pair 95 = 11.
5. Random in_valid (50%) and out_ready (30%) gaps, two back-to-back random blocks → output matches the reference-model sequence exactly. out_data and out_last are stable while out_ready=0, and in_ready=0 throughout ENCODE.
6. Reset asserted at collected bit 40, and separately at pair 50 of ENCODE → outputs idle next cycle; the following full block encodes correctly with no leftover pairs.

Source files
------------

// File: rtl/tb_conv_encoder.sv
// Rate-1/2, K=7 tail-biting convolutional encoder (G1=171o, G2=133o).
// Buffers one block of serial bits, then emits one registered (X,Y) pair per accepted cycle.
module tb_conv_encoder #(
  parameter int BLOCK_BITS = 96,
  parameter int CNT_W      = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       input_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [1:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last
);

  localparam int IDX_W = (BLOCK_BITS > 1) ? $clog2(BLOCK_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_BITS - 1);

  typedef enum logic {
    COLLECT,
    ENCODE
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_nxt;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      idx_nxt;
  logic [BLOCK_BITS-1:0] blk;
  logic [5:0]            shreg;       // shreg[0]=s1 ... shreg[5]=s6
  logic [5:0]            load_state;
  logic [5:0]            shift_state;

  function automatic logic [1:0] code_pair(input logic b, input logic [5:0] s);
    logic x;
    logic y;
    x = b ^ s[0] ^ s[1] ^ s[2] ^ s[5];
    y = b ^ s[1] ^ s[2] ^ s[4] ^ s[5];
    return {x, y};
  endfunction

  always_comb begin
    cnt_nxt     = cnt + 1'b1;
    idx         = cnt[IDX_W-1:0];
    idx_nxt     = cnt_nxt[IDX_W-1:0];
    // Tail-biting preload: the bit arriving now is d[N-1], the rest are already buffered.
    load_state  = {blk[BLOCK_BITS-6], blk[BLOCK_BITS-5], blk[BLOCK_BITS-4],
                   blk[BLOCK_BITS-3], blk[BLOCK_BITS-2], input_data};
    shift_state = {shreg[4:0], blk[idx]};
  end

  // Gated by reset so upstream sees not-ready on the reset cycle itself.
  assign in_ready = (state == COLLECT) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= COLLECT;
      cnt       <= '0;
      blk       <= '0;
      shreg     <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (in_valid) begin
            blk[idx] <= input_data;
            if (cnt == LAST) begin
              state     <= ENCODE;
              cnt       <= '0;
              shreg     <= load_state;
              out_valid <= 1'b1;
              out_last  <= 1'b0;
              out_data  <= code_pair(blk[0], load_state);
            end else begin
              cnt <= cnt_nxt;
            end
          end
        end
        ENCODE: begin
          if (out_ready) begin
            shreg <= shift_state;
            if (cnt == LAST) begin
              state     <= COLLECT;
              cnt       <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
            end else begin
              // Pair k+1 is formed from the post-shift state so it is ready next cycle.
              cnt      <= cnt_nxt;
              out_data <= code_pair(blk[idx_nxt], shift_state);
              out_last <= (cnt_nxt == LAST);
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_tb_conv_encoder.sv
// Table-driven bench for the tail-biting convolutional encoder: directed blocks,
// random handshake gaps, and mid-block resets, compared against a bit-serial model.
module tb_tb_conv_encoder;

  localparam int N = 96;

  logic       clk = 1'b0;
  logic       reset;
  logic       input_data;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  int n_checks = 0;
  int n_fail   = 0;

  tb_conv_encoder #(.BLOCK_BITS(N), .CNT_W(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .input_data (input_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    string          name;
    logic [N-1:0]   din;
    logic [2*N-1:0] pairs;
    int             in_gap;
    int             out_gap;
    int             abort_in;
    int             abort_out;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2*N-1:0] model(input logic [N-1:0] d);
    logic s1, s2, s3, s4, s5, s6, b;
    logic [2*N-1:0] r;
    s1 = d[N-1]; s2 = d[N-2]; s3 = d[N-3];
    s4 = d[N-4]; s5 = d[N-5]; s6 = d[N-6];
    r = '0;
    for (int k = 0; k < N; k++) begin
      b = d[k];
      r[2*k+1] = b ^ s1 ^ s2 ^ s3 ^ s6;
      r[2*k]   = b ^ s2 ^ s3 ^ s5 ^ s6;
      s6 = s5; s5 = s4; s4 = s3; s3 = s2; s2 = s1; s1 = b;
    end
    return r;
  endfunction

  function automatic logic [N-1:0] rand_block();
    logic [N-1:0] d;
    for (int i = 0; i < N; i++) d[i] = 1'($urandom_range(0, 1));
    return d;
  endfunction

  // Called at a negedge: one reset cycle, then idle outputs and in_ready back high.
  task automatic do_reset(input string name);
    reset    = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check({name, "/rst_in_ready"}, in_ready, 1'b0);
    check({name, "/rst_out_valid"}, out_valid, 1'b0);
    check({name, "/rst_out_last"}, out_last, 1'b0);
    check({name, "/rst_out_data"}, out_data, 2'b00);
    reset = 1'b0;
    @(negedge clk);
    check({name, "/post_rst_in_ready"}, in_ready, 1'b1);
    check({name, "/post_rst_out_valid"}, out_valid, 1'b0);
  endtask

  task automatic run_block(input vec_t v);
    int i, cyc, k, enc_cyc, last_cnt, last_pos, stab_err, rdy_err, val_err, ov_err;
    logic [2*N-1:0] got;
    logic           hold, pl;
    logic [1:0]     pd;
    logic [5:0]     st_exp;
    i = 0; cyc = 0; ov_err = 0;
    while (i < N && cyc < 20*N) begin
      @(negedge clk);
      cyc++;
      if (out_valid) ov_err++;
      if (v.abort_in >= 0 && i == v.abort_in) begin
        check({v.name, "/collect_out_valid"}, ov_err, 0);
        do_reset(v.name);
        return;
      end
      in_valid   = (int'($urandom_range(0, 99)) >= v.in_gap);
      input_data = v.din[i];
      if (in_valid && in_ready) i++;
    end
    check({v.name, "/collect_done"}, i, N);
    check({v.name, "/collect_out_valid"}, ov_err, 0);
    if (v.in_gap == 0) check({v.name, "/collect_cycles"}, cyc, N);

    k = 0; enc_cyc = 0; last_cnt = 0; last_pos = -1;
    stab_err = 0; rdy_err = 0; val_err = 0;
    hold = 1'b0; pd = '0; pl = 1'b0; got = '0;
    while (k < N && enc_cyc < 20*N) begin
      @(negedge clk);
      enc_cyc++;
      in_valid   = 1'b1;
      input_data = 1'($urandom_range(0, 1));
      if (enc_cyc == 1) check({v.name, "/pair0_latency"}, out_valid, 1'b1);
      if (in_ready) rdy_err++;
      if (!out_valid) val_err++;
      if (hold && (out_data !== pd || out_last !== pl)) stab_err++;
      if (v.abort_out >= 0 && k == v.abort_out) begin
        do_reset(v.name);
        return;
      end
      out_ready = (int'($urandom_range(0, 99)) >= v.out_gap);
      if (out_valid && out_ready) begin
        got[2*k +: 2] = out_data;
        if (out_last) begin
          last_cnt++;
          last_pos = k;
        end
        k++;
      end
      hold = out_valid && !out_ready;
      pd   = out_data;
      pl   = out_last;
    end
    st_exp = {v.din[N-6], v.din[N-5], v.din[N-4], v.din[N-3], v.din[N-2], v.din[N-1]};
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check({v.name, "/encode_done"}, k, N);
    check({v.name, "/stream"}, got, v.pairs);
    check({v.name, "/last_count_pos"}, {last_cnt, last_pos}, {32'd1, 32'(N-1)});
    check({v.name, "/stable_on_stall"}, stab_err, 0);
    check({v.name, "/in_ready_low_in_encode"}, rdy_err, 0);
    check({v.name, "/out_valid_held"}, val_err, 0);
    if (v.out_gap == 0) check({v.name, "/encode_cycles"}, enc_cyc, N);
    check({v.name, "/end_out_valid"}, out_valid, 1'b0);
    check({v.name, "/end_in_ready"}, in_ready, 1'b1);
    check({v.name, "/tailbite_state"}, dut.shreg, st_exp);
  endtask

  initial begin
    logic [N-1:0] d;

    vecs[0] = '{"all_zero", '0, '0, 0, 0, -1, -1};
    vecs[1] = '{"all_one", '1, '1, 0, 0, -1, -1};
    d = '0; d[0] = 1'b1;
    vecs[2] = '{"d0_impulse", d, '0, 0, 0, -1, -1};
    vecs[2].pairs[13:0] = 14'b11_01_00_11_11_10_11;
    d = '0; d[N-1] = 1'b1;
    vecs[3] = '{"d95_impulse", d, '0, 0, 0, -1, -1};
    vecs[3].pairs[11:0] = 12'b11_01_00_11_11_10;
    vecs[3].pairs[2*N-1 -: 2] = 2'b11;
    for (int v = 4; v < 10; v++) begin
      d = rand_block();
      vecs[v] = '{"", d, model(d), 50, 30, -1, -1};
    end
    vecs[4].name = "rand_a";
    vecs[5].name = "rand_b";
    vecs[6].name = "abort_collect"; vecs[6].abort_in = 40;
    vecs[7].name = "after_abort_collect";
    vecs[8].name = "abort_encode";  vecs[8].abort_out = 50; vecs[8].in_gap = 0; vecs[8].out_gap = 0;
    vecs[9].name = "after_abort_encode";

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; input_data = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset/in_ready", in_ready, 1'b0);
    check("reset/out_valid", out_valid, 1'b0);
    check("reset/out_last", out_last, 1'b0);
    check("reset/out_data", out_data, 2'b00);
    reset = 1'b0;
    @(negedge clk);
    check("reset/in_ready_after", in_ready, 1'b1);
    check("reset/tailbite_state_clear", dut.shreg, 6'd0);

    for (int v = 0; v < 10; v++) run_block(vecs[v]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
